sseg_scan4: RTL and testbench
=============================

# sseg_scan4

Four-digit time-multiplexed scan controller for the seven-segment display. It takes a 16-bit hex value and per-digit controls, then steps one anode at a time at a prescaled rate. For the active digit it presents the 4-bit nibble on `digit`, which feeds `sseg_decoder`. It replaces hand-driven two-digit selection with a free-running scan, plus leading-zero suppression and a tear-free per-frame snapshot.

## Interface

Parameters:
- `DIV`, default 100000: clock cycles each digit stays lit. Legal range is DIV ≥ 2. The counter width is $clog2(DIV).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `val`  in  16  display value. `val[3:0]` is digit 0 (rightmost) and `val[15:12]` is digit 3.
- `dp_in`  in  4  decimal-point request per digit, active-high; bit i belongs to digit i.
- `en_in`  in  4  digit enable, active-high. A disabled digit is blanked.
- `lz_blank`  in  1  leading-zero suppression enable.
- `digit`  out  4  nibble for `sseg_decoder`.
- `an`  out  4  anodes, active-low; `an[i]` drives digit i.
- `dp`  out  1  decimal point, active-low.
- `frame`  out  1  one-cycle pulse marking the start of each scan frame.

## Operation

- **Prescaler `cnt`:** counts 0..DIV-1 and then wraps to 0. When `cnt` equals DIV-1 it raises the advance tick.
- **Digit index `idx`** (2 bits): advances 0→1→2→3→0 on each tick and holds otherwise.
- **Snapshot load:** the snapshot registers are `s_val`, `s_dp`, `s_en` and `s_lz`.
  - They load `val`, `dp_in`, `en_in` and `lz_blank` on every edge where `cnt==0 && idx==0` (the load cycle). They hold at all other times.
  - Input changes mid-frame therefore never reach the display until the next frame.
- **Output register source:** outputs are registered. On every edge they are computed from the current `idx` and the effective snapshot.
  - The effective snapshot is the inputs on a load cycle and the snapshot registers otherwise.
  - As a result, the first digit of a frame already shows the newly loaded value.
- **Blanking rule for digit i:**
  - Digit i is blanked if `s_en[i]==0`.
  - It is also blanked if `s_lz==1`, i≠0, and every nibble from digit 3 down to digit i is zero.
  - Digit 0 is never suppressed by `lz`.
- **Digit not blanked:**
  - `an` is all ones except bit `idx`, which is 0.
  - `digit` is the nibble `idx` of the snapshot.
  - `dp` is `~s_dp[idx]`.
- **Digit blanked:** `an=4'b1111`, `digit=4'h0`, `dp=1`.
- **`frame`:** registered; goes to 1 on the load-cycle edge and to 0 on every other edge.
- **Reset:** while `rst` is sampled high, `cnt`, `idx` and all snapshot registers are cleared.
  - The outputs at that edge are `an=4'b1111`, `digit=4'h0`, `dp=1`, `frame=0`.
  - Reset takes priority over everything, including mid-frame and mid-digit.

## Timing

- **Definitions:** E1 is the first rising edge with `rst` sampled low.
- **E1:**
  - This edge is a load cycle: `cnt` goes 0→1 and the snapshot takes the inputs.
  - Outputs show digit 0 of the inputs sampled at E1, and `frame` is 1.
- **Dwell:** each digit is shown for exactly DIV edges.
  - Digit i is shown for edges E(1+i·DIV) through E((i+1)·DIV).
  - A full frame is 4·DIV cycles, with `frame` pulsing at E1, E(1+4·DIV), and so on.
- **Anode transitions:** `an` changes only on the edge after a tick, never in the middle of a dwell.
- **Reset mid-operation:** if `rst` is high at edge Er, the outputs take reset values at Er. Scanning then restarts from E1 semantics at the first edge after deassertion.
- **Simultaneous events:** a tick and a load never coincide for DIV ≥ 2, so no ordering rule is needed.

## Test plan

1. **Reset values:** set DIV=4 and hold `rst` for 3 cycles. The outputs must read `an=1111`, `digit=0`, `dp=1`, `frame=0`.
2. **Basic scan:** drive `val=16'h1234`, `en_in=4'b1111`, `lz_blank=0`, `dp_in=0` and release reset.
   - `an` must read 1110 with `digit=4` for 4 edges, then 1101/3, then 1011/2, then 0111/1, then repeat.
   - `frame` must be 1 at E1 and at E17 only.
3. **Leading-zero suppression:** drive `val=16'h0050` with `lz_blank=1`.
   - Digits 3 and 2 must be blanked (`an=1111`).
   - Digit 1 must show `an=1101`, `digit=5`.
   - Digit 0 must show `an=1110`, `digit=0`.
   - With `val=16'h0000`, only digit 0 may be lit, showing 0.
4. **Snapshot:** start with `val=16'hAAAA` and change it to `16'h5555` at E6 (during digit 1).
   - Digits 1 through 3 of this frame must still show A.
   - The frame starting at E17 must show 5.
5. **Decimal point and enable masks:**
   - Drive `dp_in=4'b0100`. `dp` must be 0 only while `an=1011`.
   - Drive `en_in=4'b1101`. Digit 1 must be blanked (`an=1111`, `dp=1`) even when its nibble is nonzero.
6. **Reset mid-frame:** assert `rst` for one cycle during digit 2 (for example at E10).
   - The outputs must take reset values at that edge.
   - The next edge must behave as E1: digit 0 with `frame=1`.

Source files
------------

// File: rtl/sseg_scan4.sv
// sseg_scan4 -- four-digit time-multiplexed seven-segment scan controller.
//
// Steps one anode at a time, each digit lit for DIV clock cycles, and presents
// the active digit's nibble for an external sseg_decoder. All display inputs are
// captured once per frame so a frame never mixes old and new values.
//
// Parameters:
//   DIV       clock cycles each digit stays lit (DIV >= 2)
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   val       16-bit display value, val[3:0] is digit 0 (rightmost)
//   dp_in     per-digit decimal-point request, active-high
//   en_in     per-digit enable, active-high; disabled digits are blanked
//   lz_blank  leading-zero suppression enable
//   digit     nibble of the active digit (0 when blanked)
//   an        anodes, active-low, an[i] drives digit i
//   dp        decimal point, active-low
//   frame     one-cycle pulse on the first digit of every scan frame
module sseg_scan4 #(
    parameter int unsigned DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] val,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  en_in,
    input  logic        lz_blank,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   s_val;
    logic [3:0]    s_dp;
    logic [3:0]    s_en;
    logic          s_lz;

    logic          tick;
    logic          load;
    logic [15:0]   e_val;
    logic [3:0]    e_dp;
    logic [3:0]    e_en;
    logic          e_lz;
    logic [3:0]    upper_zero;
    logic          blank;
    logic [3:0]    an_nx;
    logic [3:0]    digit_nx;
    logic          dp_nx;

    always_comb begin
        tick = (cnt == CNT_MAX);
        load = (cnt == '0) && (idx == 2'd0);

        // On the load cycle the outputs are built from the inputs being
        // captured, so the first digit of a frame already shows the new value.
        e_val = load ? val      : s_val;
        e_dp  = load ? dp_in    : s_dp;
        e_en  = load ? en_in    : s_en;
        e_lz  = load ? lz_blank : s_lz;

        // upper_zero[i]: every nibble from digit 3 down to digit i is zero.
        upper_zero[3] = (e_val[15:12] == 4'h0);
        upper_zero[2] = (e_val[15:8]  == 8'h00);
        upper_zero[1] = (e_val[15:4]  == 12'h000);
        upper_zero[0] = (e_val        == 16'h0000);

        blank = !e_en[idx] || (e_lz && (idx != 2'd0) && upper_zero[idx]);

        an_nx    = '1;
        digit_nx = '0;
        dp_nx    = 1'b1;
        if (!blank) begin
            an_nx    = ~(4'b0001 << idx);
            digit_nx = e_val[{idx, 2'b00} +: 4];
            dp_nx    = ~e_dp[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= '0;
            s_val <= '0;
            s_dp  <= '0;
            s_en  <= '0;
            s_lz  <= 1'b0;
            an    <= '1;
            digit <= '0;
            dp    <= 1'b1;
            frame <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= idx + 2'd1;
            end
            if (load) begin
                s_val <= val;
                s_dp  <= dp_in;
                s_en  <= en_in;
                s_lz  <= lz_blank;
            end
            an    <= an_nx;
            digit <= digit_nx;
            dp    <= dp_nx;
            frame <= load;
        end
    end

endmodule

// File: tb/tb_sseg_scan4.sv
// tb_sseg_scan4 -- self-checking bench for sseg_scan4 (DIV = 4).
// A reference model tracks the edge number since reset release and derives the
// expected display from frame position arithmetic and a per-frame snapshot.
module tb_sseg_scan4;

    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] val = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  en_in = '0;
    logic        lz_blank = 1'b0;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        dp;
    logic        frame;

    sseg_scan4 #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .val      (val),
        .dp_in    (dp_in),
        .en_in    (en_in),
        .lz_blank (lz_blank),
        .digit    (digit),
        .an       (an),
        .dp       (dp),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    int unsigned t = 0;          // edges since reset release; next edge is E(t+1)
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp  = '0;
    logic [3:0]  m_en  = '0;
    logic        m_lz  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    // Advance one clock edge, update the model from the inputs sampled at that
    // edge, and compare all outputs shortly after the edge.
    task automatic step();
        logic [3:0]  x_an;
        logic [3:0]  x_digit;
        logic        x_dp;
        logic        x_frame;
        int unsigned k;
        int unsigned i;
        logic        lit;
        @(posedge clk);
        if (rst) begin
            t       = 0;
            x_an    = 4'b1111;
            x_digit = 4'h0;
            x_dp    = 1'b1;
            x_frame = 1'b0;
        end else begin
            k = t % FRAME;
            if (k == 0) begin
                m_val = val;
                m_dp  = dp_in;
                m_en  = en_in;
                m_lz  = lz_blank;
            end
            i   = k / DIV;
            lit = m_en[i] && !(m_lz && i != 0 && ((m_val >> (4 * i)) == 16'h0000));
            x_an    = lit ? (4'b1111 ^ (4'b0001 << i)) : 4'b1111;
            x_digit = lit ? 4'((m_val >> (4 * i)) & 16'h000F) : 4'h0;
            x_dp    = lit ? !m_dp[i] : 1'b1;
            x_frame = (k == 0);
            t++;
        end
        #1;
        check("an",    32'(an),    32'(x_an));
        check("digit", 32'(digit), 32'(x_digit));
        check("dp",    32'(dp),    32'(x_dp));
        check("frame", 32'(frame), 32'(x_frame));
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned c = 0; c < n; c++) step();
    endtask

    initial begin
        // 1. Reset values
        rst = 1'b1;
        run(3);

        // 2. Basic scan over two frames
        val = 16'h1234; en_in = 4'b1111; lz_blank = 1'b0; dp_in = 4'b0000;
        rst = 1'b0;
        run(2 * FRAME);

        // 3. Leading-zero suppression
        rst = 1'b1; val = 16'h0050; lz_blank = 1'b1;
        run(1);
        rst = 1'b0;
        run(FRAME);
        val = 16'h0000;
        run(FRAME);
        val = 16'h0300;
        run(FRAME);

        // 4. Snapshot: change value at E6 (mid digit 1)
        rst = 1'b1; val = 16'hAAAA; lz_blank = 1'b0;
        run(1);
        rst = 1'b0;
        run(5);
        val = 16'h5555;
        run(FRAME + FRAME - 5);

        // 5. Decimal point and enable masks
        dp_in = 4'b0100; en_in = 4'b1111; val = 16'h9876;
        run(FRAME);
        dp_in = 4'b0010; en_in = 4'b1101;
        run(2 * FRAME);

        // 6. Reset mid-frame at E10
        rst = 1'b1; en_in = 4'b1111; dp_in = 4'b0000; val = 16'h4321;
        run(1);
        rst = 1'b0;
        run(9);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(FRAME + 2);

        // 7. Randomized inputs with occasional reset
        for (int unsigned n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) begin
                val = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
                dp_in    = 4'($urandom);
                en_in    = 4'($urandom);
                lz_blank = 1'($urandom);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
